msk_sbox_selftest: RTL
======================

// Module: msk_sbox_selftest
// PURPOSE
//  Synthesizable on-chip self-test sequencer for one masked AES S-box
//  (bp_aes_sbox_msk_dual style: d shares per bit, valid_in/valid_out).
//  Sweeps all byte inputs in forward, inverse or both directions, shares
//  each input (optionally with fresh LFSR masks), recombines the DUT output
//  and compares it with an internal sbox_bp_umsk reference.
//  Reports pass/fail and the first failing vector; sits beside the S-box in
//  the full-AES datapath and is muxed onto the S-box inputs during test.
// PARAMETERS
//  d             2        number of shares per bit (>=2)
//  MODE          0        0 forward only, 1 inverse only, 2 forward then inverse
//  RANDOM_SHARES 0        0: shares 1..d-1 = 0; 1: shares 1..d-1 from LFSR
//  TIMEOUT       16       max cycles from issue to sb_valid_out (>=2)
//  LFSR_SEED     32'hACE1 nonzero seed of internal 32-bit Galois LFSR
// PORTS
//  clk           in   1     clock, all logic on rising edge
//  rst           in   1     synchronous reset, active-low (0 = reset)
//  start         in   1     1-cycle pulse; launches a sweep when idle
//  sb_enable     out  1     enable to S-box; 1 whenever busy
//  sb_valid_in   out  1     one-cycle input strobe to S-box
//  sb_inverse    out  1     S-box direction for current vector
//  sb_in_sh      out  8*d   shared input, bit i in [i*d +: d]
//  sb_out_sh     in   8*d   shared output from S-box, same layout
//  sb_valid_out  in   1     S-box output valid
//  busy          out  1     sweep in progress
//  done          out  1     sweep finished (pass or fail), held until next start
//  pass          out  1     valid with done: all vectors matched
//  fail_code     out  2     0 none, 1 mismatch, 2 timeout, 3 spurious valid_out
//  fail_input    out  8     unshared input of failing vector
//  fail_inverse  out  1     direction of failing vector
//  fail_expected out  8     reference output of failing vector
//  fail_got      out  8     recombined DUT output (0 on timeout/spurious)
//  vec_count     out  10    vectors checked successfully so far
// BEHAVIOUR
//  - Reset (rst=0 at edge): FSM->IDLE; every output 0; LFSR<=LFSR_SEED.
//    Reset mid-sweep aborts; nothing retained; next start restarts at 0x00.
//  - FSM IDLE -> ISSUE -> WAIT -> (ISSUE | DONE); DONE -> ISSUE on start.
//  - IDLE/DONE: start=1 clears done/pass/fail_*/vec_count, vec<=0, dir<=
//    (MODE==1), goes ISSUE next cycle. start while busy is ignored.
//  - ISSUE (1 cycle): sb_valid_in=1; sb_in_sh shares 1..d-1 = LFSR bits (or 0),
//    share 0 = vec bit ^ XOR(other shares); LFSR advances 8*(d-1) bits/vector.
//    Input byte and dir registered for the compare. Wait counter <= 0.
//  - WAIT: counter++ each cycle. sb_valid_out=1: recombine (XOR of d shares
//    per bit), compare with reference(vec,dir) in the same cycle.
//    Match: vec_count++, advance; mismatch: fail_code=1, capture fail_*.
//    Counter reaching TIMEOUT with no valid_out: fail_code=2.
//  - sb_valid_out=1 while in ISSUE or IDLE-with-busy: fail_code=3.
//  - Advance: vec<0xFF -> vec++, ISSUE; vec==0xFF and MODE==2 and dir==0 ->
//    vec<=0, dir<=1, ISSUE; else DONE with pass=1.
//  - Any fail: DONE, pass=0, busy=0, vec_count frozen at matched count.
//  - done/pass/fail_* registered, change only on DONE entry or start.
//  - sb_inverse constant for a whole direction pass; sb_in_sh held between
//    strobes (masks not refreshed until next ISSUE).
//  - Min per-vector period = DUT latency + 1 cycle (one vector in flight).
//  - vec_count max 512 (MODE 2); 10 bits, never wraps.
// TESTING
//  1 d=2 MODE=0 real masked S-box, start -> done=1 pass=1 vec_count=256,
//    fail_code=0; exactly 256 sb_valid_in pulses.
//  2 MODE=2 -> vec_count=512, pass=1; sb_inverse=0 for first 256 strobes, 1 after.
//  3 Stub flips out bit0 for fwd input 0x53 -> fail_code=1 fail_input=0x53
//    fail_expected=0xED fail_got=0xEC vec_count=0x53 fail_inverse=0.
//  4 Stub never raises valid_out, TIMEOUT=16 -> done 16 cycles after first
//    issue, fail_code=2 fail_input=0x00 fail_got=0 pass=0.
//  5 rst=0 during vector ~0x64 -> next cycle all outputs 0, busy=0; new start
//    sweeps from 0x00 and passes.
//  6 d=3 RANDOM_SHARES=1: shares 1,2 vary across strobes, XOR of 3 shares =
//    vec each strobe; start during busy ignored; sweep passes.

Source files
------------

// File: rtl/msk_sbox_selftest.sv
// Self-test sequencer for one masked AES S-box. It sweeps every byte input in
// the forward and/or inverse direction, shares each input, recombines the
// S-box output and checks it against an unmasked reference. It records the
// first failing vector.
module msk_sbox_selftest #(
  parameter int unsigned d             = 2,
  parameter int unsigned MODE          = 0,
  parameter int unsigned RANDOM_SHARES = 0,
  parameter int unsigned TIMEOUT       = 16,
  parameter logic [31:0] LFSR_SEED     = 32'hACE1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           sb_enable,
  output logic           sb_valid_in,
  output logic           sb_inverse,
  output logic [8*d-1:0] sb_in_sh,
  input  logic [8*d-1:0] sb_out_sh,
  input  logic           sb_valid_out,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [1:0]     fail_code,
  output logic [7:0]     fail_input,
  output logic           fail_inverse,
  output logic [7:0]     fail_expected,
  output logic [7:0]     fail_got,
  output logic [9:0]     vec_count
);

  localparam int unsigned CntW  = $clog2(TIMEOUT);
  localparam int unsigned MaskW = 8 * (d - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [31:0] LfsrPoly = 32'h80200003;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e           state_q, state_d;
  logic [7:0]       vec_q, vec_d;
  logic             dir_q, dir_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [31:0]      lfsr_q, lfsr_d, lfsr_adv;
  logic [8*d-1:0]   in_sh_q, in_sh_d;
  logic [MaskW-1:0] mask;
  logic             done_q, done_d, pass_q, pass_d;
  logic [1:0]       code_q, code_d;
  logic [7:0]       fin_q, fin_d, fexp_q, fexp_d, fgot_q, fgot_d;
  logic             finv_q, finv_d;
  logic [9:0]       cnt_ok_q, cnt_ok_d;
  logic [7:0]       got, ref_byte;
  logic             load, fail_now;
  logic [1:0]       fail_kind;
  logic [7:0]       fail_val;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x, input logic inv);
    logic [7:0] t;
    if (inv) begin
      t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      return gf_inv(t);
    end
    t = gf_inv(x);
    return t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]} ^ {t[3:0], t[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LfsrPoly) : (s >> 1);
  endfunction

  // Share 0 absorbs the unshared bit so the XOR of all shares equals v.
  function automatic logic [8*d-1:0] share_vec(input logic [7:0] v, input logic [MaskW-1:0] m);
    logic [8*d-1:0] s;
    logic           acc;
    s = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      acc = v[i];
      for (int unsigned j = 1; j < d; j++) begin
        s[i*d+j] = (RANDOM_SHARES != 0) && m[i*(d-1)+j-1];
        acc      = acc ^ s[i*d+j];
      end
      s[i*d] = acc;
    end
    return s;
  endfunction

  // Mask bits for the next vector, drawn one LFSR step per bit.
  always_comb begin
    lfsr_adv = lfsr_q;
    mask     = '0;
    for (int unsigned k = 0; k < MaskW; k++) begin
      mask[k]  = lfsr_adv[0];
      lfsr_adv = lfsr_step(lfsr_adv);
    end
  end

  // Recombine the S-box output shares and form the reference value.
  always_comb begin
    got = '0;
    for (int unsigned i = 0; i < 8; i++) got[i] = ^sb_out_sh[i*d +: d];
    ref_byte = sbox_ref(vec_q, dir_q);
  end

  // Sequencer next-state logic.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    in_sh_d   = in_sh_q;
    done_d    = done_q;
    pass_d    = pass_q;
    code_d    = code_q;
    fin_d     = fin_q;
    finv_d    = finv_q;
    fexp_d    = fexp_q;
    fgot_d    = fgot_q;
    cnt_ok_d  = cnt_ok_q;
    load      = 1'b0;
    fail_now  = 1'b0;
    fail_kind = 2'd0;
    fail_val  = 8'h00;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          done_d   = 1'b0;
          pass_d   = 1'b0;
          code_d   = 2'd0;
          fin_d    = 8'h00;
          finv_d   = 1'b0;
          fexp_d   = 8'h00;
          fgot_d   = 8'h00;
          cnt_ok_d = '0;
          vec_d    = 8'h00;
          dir_d    = (MODE == 1);
          load     = 1'b1;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
        // Nothing is in flight yet, so a response here is spurious.
        if (sb_valid_out) begin
          fail_now  = 1'b1;
          fail_kind = 2'd3;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (sb_valid_out) begin
          if (got == ref_byte) begin
            cnt_ok_d = cnt_ok_q + 10'd1;
            if (vec_q != 8'hFF) begin
              vec_d   = vec_q + 8'd1;
              load    = 1'b1;
              state_d = StIssue;
            end else if (MODE == 2 && !dir_q) begin
              vec_d   = 8'h00;
              dir_d   = 1'b1;
              load    = 1'b1;
              state_d = StIssue;
            end else begin
              done_d  = 1'b1;
              pass_d  = 1'b1;
              state_d = StDone;
            end
          end else begin
            fail_now  = 1'b1;
            fail_kind = 2'd1;
            fail_val  = got;
          end
        end else if (cnt_q == CntLast) begin
          fail_now  = 1'b1;
          fail_kind = 2'd2;
        end
      end
      default: state_d = StIdle;
    endcase
    if (fail_now) begin
      done_d  = 1'b1;
      pass_d  = 1'b0;
      code_d  = fail_kind;
      fin_d   = vec_q;
      finv_d  = dir_q;
      fexp_d  = ref_byte;
      fgot_d  = fail_val;
      state_d = StDone;
    end
    if (load) begin
      in_sh_d = share_vec(vec_d, mask);
      lfsr_d  = lfsr_adv;
    end
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      vec_q    <= '0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      in_sh_q  <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      code_q   <= '0;
      fin_q    <= '0;
      finv_q   <= 1'b0;
      fexp_q   <= '0;
      fgot_q   <= '0;
      cnt_ok_q <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      in_sh_q  <= in_sh_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      code_q   <= code_d;
      fin_q    <= fin_d;
      finv_q   <= finv_d;
      fexp_q   <= fexp_d;
      fgot_q   <= fgot_d;
      cnt_ok_q <= cnt_ok_d;
    end
  end

  assign busy          = (state_q == StIssue) || (state_q == StWait);
  assign sb_enable     = busy;
  assign sb_valid_in   = (state_q == StIssue);
  assign sb_inverse    = dir_q;
  assign sb_in_sh      = in_sh_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail_code     = code_q;
  assign fail_input    = fin_q;
  assign fail_inverse  = finv_q;
  assign fail_expected = fexp_q;
  assign fail_got      = fgot_q;
  assign vec_count     = cnt_ok_q;

endmodule
